// File: rtl/soc_system_pio_pkg.sv
// Shared constants for the lightweight-bridge PIO blocks.
//   ADDR_*  : Avalon word addresses of the slave registers
//   EDGE_*  : encodings for the EDGE_TYPE parameter of the input PIO
package soc_system_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/soc_system_pio_debounce.sv
// Single-bit input conditioner: 2-FF synchroniser followed by a stability
// counter. A change on the synchronised input is accepted only after it has
// been seen for DEBOUNCE_CYCLES consecutive cycles.
// Ports:
//   clk      system clock
//   reset_n  synchronous active-low reset
//   din      raw asynchronous pin
//   dout     debounced level (RESET_VALUE after reset)
module soc_system_pio_debounce #(
    parameter int   DEBOUNCE_CYCLES = 50000,
    parameter logic RESET_VALUE     = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic dout
);

    // Wide enough to hold DEBOUNCE_CYCLES; the count clears before it can wrap.
    localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_q1;
    logic          sync_q2;
    logic          deb_q;
    logic [CW-1:0] count;

    // NOTE: non-blocking assignments here so every flop samples pre-edge
    // values; blocking would collapse the two synchroniser stages into one.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q1 <= RESET_VALUE;
            sync_q2 <= RESET_VALUE;
            deb_q   <= RESET_VALUE;
            count   <= '0;
        end else begin
            sync_q1 <= din;
            sync_q2 <= sync_q1;
            if (sync_q2 == deb_q) begin
                count <= '0;
            end else if (count == CNT_LAST) begin
                deb_q <= sync_q2;
                count <= '0;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

    assign dout = deb_q;

endmodule

// File: rtl/soc_system_pio_key_in.sv
// Avalon-MM input PIO for push-buttons/switches on the HPS lightweight bridge.
// Each pin is synchronised and debounced, selected edges are latched into a
// sticky W1C edgecapture register, and irq is raised while any captured edge
// is unmasked.
// Ports:
//   clk, reset_n  clock and synchronous active-low reset
//   address       0 data, 2 irqmask, 3 edgecapture (1 reads zero)
//   chipselect    slave select
//   write_n       active-low write strobe
//   writedata     write data (bits above WIDTH ignored)
//   in_port       raw pin inputs
//   readdata      registered read data, latency 1, zero-extended
//   irq           level interrupt = |(edgecapture & irqmask)
module soc_system_pio_key_in
    import soc_system_pio_pkg::*;
#(
    parameter int               WIDTH           = 4,
    parameter int               DEBOUNCE_CYCLES = 50000,
    parameter int               EDGE_TYPE       = EDGE_FALL,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] debounced;
    logic [WIDTH-1:0] debounced_d;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] clear_bits;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecapture;
    logic [31:0]      rd_next;
    logic             wr_en;
    logic             unused_wdata;

    // Upper writedata bits are architecturally ignored.
    assign unused_wdata = ^writedata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        soc_system_pio_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_VALUE     (RESET_VALUE[i])
        ) u_debounce (
            .clk     (clk),
            .reset_n (reset_n),
            .din     (in_port[i]),
            .dout    (debounced[i])
        );
    end

    assign wr_en = chipselect & ~write_n;

    // NOTE: every output of this block gets a default first so no path
    // leaves a variable unassigned, which would infer a latch.
    always_comb begin
        edge_hit   = '0;
        clear_bits = '0;
        rd_next    = '0;
        case (EDGE_TYPE)
            EDGE_RISE: edge_hit = debounced & ~debounced_d;
            EDGE_FALL: edge_hit = ~debounced & debounced_d;
            default:   edge_hit = debounced ^ debounced_d;
        endcase
        if (wr_en && address == ADDR_EDGECAP) begin
            clear_bits = writedata[WIDTH-1:0];
        end
        case (address)
            ADDR_DATA:    rd_next[WIDTH-1:0] = debounced;
            ADDR_IRQMASK: rd_next[WIDTH-1:0] = irqmask;
            ADDR_EDGECAP: rd_next[WIDTH-1:0] = edgecapture;
            default:      rd_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            // Delayed copy matches the debounced reset value so leaving reset
            // never looks like an edge.
            debounced_d <= RESET_VALUE;
            irqmask     <= '0;
            edgecapture <= '0;
            readdata    <= '0;
        end else begin
            debounced_d <= debounced;
            if (wr_en && address == ADDR_IRQMASK) begin
                irqmask <= writedata[WIDTH-1:0];
            end
            // OR-ing the new edges after the clear makes a same-cycle set win.
            edgecapture <= (edgecapture & ~clear_bits) | edge_hit;
            readdata    <= rd_next;
        end
    end

    assign irq = |(edgecapture & irqmask);

endmodule

// File: tb/tb_soc_system_pio_key_in.sv
module tb_soc_system_pio_key_in;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        string       name;
        logic [3:0]  pins;
        logic        wr;
        logic [1:0]  waddr;
        logic [31:0] wdata;
        int          settle;
        logic [1:0]  raddr;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[$];

    soc_system_pio_key_in #(
        .WIDTH           (4),
        .DEBOUNCE_CYCLES (8),
        .EDGE_TYPE       (1),
        .RESET_VALUE     (4'hF)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        step();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic read_check(input string name, input logic [1:0] a, input logic [31:0] exp);
        address = a;
        step();
        check(name, readdata, exp);
    endtask

    initial begin
        reset_n    = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 2'd0;
        writedata  = '0;
        in_port    = 4'h0;

        // Reset: pins low during reset are ignored; state comes from RESET_VALUE.
        repeat (3) step();
        check("rst_readdata", readdata, 32'h0);
        check("rst_irq", irq, 1'b0);
        reset_n = 1'b1;
        in_port = 4'hF;
        read_check("rst_data", 2'd0, 32'hF);
        read_check("rst_mask", 2'd2, 32'h0);
        read_check("rst_edgecap", 2'd3, 32'h0);
        check("rst_irq_after", irq, 1'b0);

        // Debounce latency: 2 sync edges + 8 stable cycles -> debounced on edge 10,
        // readdata one edge later.
        in_port = 4'hE;
        address = 2'd0;
        repeat (9) step();
        check("deb_edge9", dut.debounced, 4'hF);
        step();
        check("deb_edge10", dut.debounced, 4'hE);
        check("rd_edge10", readdata, 32'hF);
        step();
        check("rd_edge11", readdata, 32'hE);
        repeat (9) step();
        read_check("deb_edgecap", 2'd3, 32'h1);
        check("deb_irq_masked", irq, 1'b0);

        // 5-cycle glitch on bit1 must not pass.
        in_port = 4'hC;
        repeat (5) step();
        in_port = 4'hE;
        repeat (15) step();
        read_check("glitch_data", 2'd0, 32'hE);
        read_check("glitch_edgecap", 2'd3, 32'h1);
        bus_write(2'd3, 32'hF);
        read_check("clear_all", 2'd3, 32'h0);

        vecs.push_back('{"mask_wr1",      4'hE, 1'b1, 2'd2, 32'h1,        2,  2'd2, 32'h1, 1'b0});
        vecs.push_back('{"rise_b0_data",  4'hF, 1'b0, 2'd0, 32'h0,        14, 2'd0, 32'hF, 1'b0});
        vecs.push_back('{"rise_no_cap",   4'hF, 1'b0, 2'd0, 32'h0,        1,  2'd3, 32'h0, 1'b0});
        vecs.push_back('{"fall_b0_cap",   4'hE, 1'b0, 2'd0, 32'h0,        14, 2'd3, 32'h1, 1'b1});
        vecs.push_back('{"w1c_b0",        4'hE, 1'b1, 2'd3, 32'h1,        1,  2'd3, 32'h0, 1'b0});
        vecs.push_back('{"wr_addr0_ign",  4'hE, 1'b1, 2'd0, 32'h0,        1,  2'd0, 32'hE, 1'b0});
        vecs.push_back('{"wr_addr1_ign",  4'hE, 1'b1, 2'd1, 32'hFFFFFFFF, 1,  2'd1, 32'h0, 1'b0});
        vecs.push_back('{"mask_kept",     4'hE, 1'b0, 2'd0, 32'h0,        1,  2'd2, 32'h1, 1'b0});
        vecs.push_back('{"fall_b2_mask",  4'hA, 1'b0, 2'd0, 32'h0,        14, 2'd3, 32'h4, 1'b0});
        vecs.push_back('{"mask_wr4",      4'hA, 1'b1, 2'd2, 32'h4,        1,  2'd2, 32'h4, 1'b1});
        vecs.push_back('{"mask_hi_ign",   4'hA, 1'b1, 2'd2, 32'hFFFFFFF0, 1,  2'd2, 32'h0, 1'b0});
        vecs.push_back('{"mask_wr5",      4'hA, 1'b1, 2'd2, 32'h5,        1,  2'd3, 32'h4, 1'b1});
        vecs.push_back('{"w1c_b2",        4'hA, 1'b1, 2'd3, 32'h4,        1,  2'd3, 32'h0, 1'b0});

        foreach (vecs[k]) begin
            in_port = vecs[k].pins;
            if (vecs[k].wr) bus_write(vecs[k].waddr, vecs[k].wdata);
            address = vecs[k].raddr;
            repeat (vecs[k].settle) step();
            check({vecs[k].name, "_rd"}, readdata, vecs[k].exp_rd);
            check({vecs[k].name, "_irq"}, irq, vecs[k].exp_irq);
        end

        // Collision: W1C of bit0 lands on the same edge as a new falling edge.
        in_port = 4'hB;
        repeat (14) step();
        in_port = 4'hA;
        repeat (14) step();
        read_check("coll_pre_cap", 2'd3, 32'h1);
        check("coll_pre_irq", irq, 1'b1);
        in_port = 4'hB;
        repeat (14) step();
        read_check("coll_rise_kept", 2'd3, 32'h1);
        in_port = 4'hA;
        address = 2'd3;
        repeat (10) step();
        check("coll_deb_fell", dut.debounced, 4'hA);
        bus_write(2'd3, 32'h1);
        check("coll_irq", irq, 1'b1);
        step();
        check("coll_edgecap", readdata, 32'h1);

        // Reset mid-operation with edgecapture = 3 and a pending pin change.
        in_port = 4'h8;
        repeat (14) step();
        read_check("mid_edgecap3", 2'd3, 32'h3);
        in_port = 4'hF;
        repeat (7) step();
        check("mid_pending", dut.debounced, 4'h8);
        reset_n = 1'b0;
        repeat (2) step();
        check("mid_rst_rd", readdata, 32'h0);
        check("mid_rst_irq", irq, 1'b0);
        reset_n = 1'b1;
        read_check("mid_data", 2'd0, 32'hF);
        read_check("mid_mask", 2'd2, 32'h0);
        read_check("mid_edgecap", 2'd3, 32'h0);
        repeat (15) step();
        check("mid_no_spurious", readdata, 32'h0);
        check("mid_irq", irq, 1'b0);
        read_check("mid_data_late", 2'd0, 32'hF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
